// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory responder: FSM states,
// default geometry, and the byte-address to word-index/error decode.
package mem_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DEPTH   = 64;
  localparam int DEF_LATENCY = 2;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic [29:0] idx;
    logic        err;
  } addr_dec_t;

  // Addresses arrive zero-extended to 32 bits, so this works for any ADDR_W up to 32.
  function automatic addr_dec_t decode_addr(input logic [31:0] addr,
                                            input logic [31:0] depth);
    addr_dec_t dec;
    dec.idx = addr[31:2];
    dec.err = (addr[1:0] != 2'b00) || ({2'b00, dec.idx} >= depth);
    return dec;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: one synchronous write port, one combinational
// read port, contents cleared by the asynchronous reset.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: this array is built from flops rather than a RAM macro because the
  // block must come out of reset with every word cleared; a RAM cannot be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: accepts one word request, waits LATENCY cycles,
// performs the access, then holds the response until it is consumed.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  addr_dec_t         dec;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic              unused_idx_hi;

  assign dec           = decode_addr(32'(addr_q), 32'(DEPTH));
  assign word_idx      = dec.idx[IDX_W-1:0];
  assign unused_idx_hi = ^dec.idx[29:IDX_W];

  // The store lands on the same edge that moves WAIT to RESP; erroring stores never write.
  assign mem_we = (state_q == WAIT) && (cnt_q == '0) && we_q && !dec.err;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst_n (reset),
    .we    (mem_we),
    .idx   (word_idx),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // NOTE: every variable gets its hold value first, so no path through the
  // case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          err_d   = dec.err;
          rdata_d = (we_q || dec.err) ? '0 : mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
